// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
// Types and constants shared by the fetch unit, the decoder and their benches.
package cpu_pkg;

   localparam int INSTR_WIDTH = 6;

   typedef logic [INSTR_WIDTH-1:0] instr_t;

   localparam instr_t OP_ADD       = 6'd0;
   localparam instr_t OP_SUB       = 6'd1;
   localparam instr_t OP_AND       = 6'd2;
   localparam instr_t OP_OR        = 6'd3;
   localparam instr_t OP_XOR       = 6'd4;
   localparam instr_t OP_NOT       = 6'd5;
   localparam instr_t OP_SHL       = 6'd6;
   localparam instr_t OP_REG_WRITE = 6'd7;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      HOLD = 3'd3,
      HALT = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
`timescale 1ns/1ps
// Program-memory read port plus the instruction handshake towards the decoder.
// The master side is the fetch unit; the slave side is memory plus decoder.
interface instruction_fetch_unit_if #(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
);
   logic [ADDR_WIDTH-1:0]  mem_addr;
   logic                   mem_rd_en;
   logic [INSTR_WIDTH-1:0] mem_rdata;
   logic                   mem_rvalid;
   logic [INSTR_WIDTH-1:0] instr_out;
   logic                   instr_valid;
   logic                   instr_ready;

   modport master (
      output mem_addr, mem_rd_en, instr_out, instr_valid,
      input  mem_rdata, mem_rvalid, instr_ready
   );

   modport slave (
      input  mem_addr, mem_rd_en, instr_out, instr_valid,
      output mem_rdata, mem_rvalid, instr_ready
   );
endinterface

// File: rtl/instruction_fetch_unit_program_counter.sv
`timescale 1ns/1ps
// Program counter register; a load always wins over an increment.
module program_counter #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] pc
);
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load) begin
         pc_d = load_addr;
      end else if (inc) begin
         pc_d = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
`timescale 1ns/1ps
// Fetches one program word per request, holds it for the decoder until accepted,
// then advances or reloads the PC; stops after the last program word.
module instruction_fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
   parameter int PROG_LEN    = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_load_addr,
   output logic                  halted,
   instruction_fetch_unit_if.master bus
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_LEN - 1);

   fetch_state_t           state_q, state_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]  pc;
   logic                   pc_ld;
   logic                   pc_inc;

   program_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc (
      .clk       (clk),
      .rst       (rst),
      .load      (pc_ld),
      .load_addr (pc_load_addr),
      .inc       (pc_inc),
      .pc        (pc)
   );

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pc_ld   = 1'b0;
      pc_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            // The load lands in the same edge as the REQ transition, so the fetch sees it.
            pc_ld = pc_load;
            if (run) begin
               state_d = REQ;
            end
         end
         REQ: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (bus.mem_rvalid) begin
               instr_d = bus.mem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (bus.instr_ready) begin
               if (pc_load) begin
                  pc_ld   = 1'b1;
                  state_d = run ? REQ : IDLE;
               end else if (pc == LAST_ADDR) begin
                  state_d = HALT;
               end else begin
                  pc_inc  = 1'b1;
                  state_d = run ? REQ : IDLE;
               end
            end
         end
         HALT: begin
            if (pc_load) begin
               pc_ld   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
      end
   end

   assign bus.mem_addr    = pc;
   assign bus.mem_rd_en   = (state_q == REQ);
   assign bus.instr_out   = instr_q;
   assign bus.instr_valid = (state_q == HOLD);
   assign halted          = (state_q == HALT);
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Supplies the 6-bit instruction stream consumed by instruction_decoder.
- Holds the program counter (PC) and reads program memory one word at a time.
- Presents each word with a valid/ready handshake, advances or reloads the PC, and halts at the end of the program.
- Sits between the program ROM and instruction_decoder.

Parameters:
- ADDR_WIDTH, 8, program memory address width.
- INSTR_WIDTH, 6, instruction width; must match the decoder input.
- PROG_LEN, 256, number of valid program words; the last address is PROG_LEN-1, and PROG_LEN ≤ 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; 1 allows new fetches.
- pc_load  input  1  request to load the PC.
- pc_load_addr  input  ADDR_WIDTH  new PC value.
- mem_addr  output  ADDR_WIDTH  program memory address, always equal to the PC.
- mem_rd_en  output  1  one-cycle read strobe.
- mem_rdata  input  INSTR_WIDTH  read data.
- mem_rvalid  input  1  read data is valid; arrives 1 or more cycles after mem_rd_en.
- instr_out  output  INSTR_WIDTH  instruction to the decoder.
- instr_valid  output  1  instr_out is valid.
- instr_ready  input  1  decoder accepts instr_out.
- halted  output  1  end of program reached.

Behaviour:
- Clocking and reset: one clock; synchronous, active-high reset.
- Reset values: state=IDLE, pc=0, mem_rd_en=0, instr_out=0, instr_valid=0, halted=0.
- Outputs: all are registered or decoded from the state only; no input-to-output combinational path.
- IDLE:
  - pc_load=1: pc<=pc_load_addr (checked first).
  - run=1: go to REQ; the fetch uses the updated PC.
  - If both are asserted in the same cycle, the load applies and the fetch uses the new address.
- REQ:
  - mem_rd_en=1 for exactly one cycle, mem_addr=pc.
  - Next state is WAIT.
- WAIT:
  - No timeout; waits indefinitely for mem_rvalid.
  - On mem_rvalid=1: instr_out<=mem_rdata, instr_valid<=1, go to HOLD.
- HOLD:
  - instr_out and instr_valid stay stable until instr_ready=1.
  - Handshake is instr_valid & instr_ready.
  - On handshake:
    - instr_valid<=0.
    - Next PC:
      - pc_load=1: next PC is pc_load_addr (no halt check).
      - Else if pc==PROG_LEN-1: go to HALT, halted<=1, PC unchanged.
      - Else: pc<=pc+1.
    - If not halting: next state is REQ if run=1, otherwise IDLE.
- HALT:
  - instr_valid=0, mem_rd_en=0, halted=1.
  - pc_load=1: halted<=0, pc<=pc_load_addr, go to IDLE.
  - Otherwise stays in HALT until reset.
- run deasserted mid-fetch (REQ, WAIT or HOLD): the in-flight fetch completes and is issued; after the handshake the block goes to IDLE.
- pc_load in REQ or WAIT, or in HOLD without a handshake: ignored, not queued.
- mem_rvalid outside WAIT: ignored; instr_out is unchanged.
- PC arithmetic: ADDR_WIDTH bits, unsigned. Wrap never occurs because of the PROG_LEN halt. pc_load_addr ≥ PROG_LEN is accepted as-is; the halt compare is equality only.
- rst in any state: restores the reset values next cycle; an outstanding memory response is discarded.
- Latency: with 1-cycle memory, run=1 in IDLE at cycle 0 gives REQ at c1, mem_rvalid at c2, instr_valid at c3. Steady state is one instruction per 3 cycles with ready held at 1.

Decomposition:
- Shared package cpu_pkg:
  - INSTR_WIDTH=6 (shared with the decoder).
  - typedef instr_t = logic [INSTR_WIDTH-1:0].
  - Opcode constants (ALU ops 0–6, OP_REG_WRITE=7) for bench use.
  - enum fetch_state_t {IDLE, REQ, WAIT, HOLD, HALT}.
- One sub-module, program_counter: holds pc; inputs are load, load_addr and inc; load has priority over inc.
- FSM and handshake stay in instruction_fetch_unit.

Test Plan:
- Basic fetch: rst, then run=1, ROM[0]=6'b011110, 1-cycle memory, ready=1 → mem_rd_en at c1 with addr 0; instr_out=6'b011110 and instr_valid at c3; next mem_rd_en at c4 with addr 1.
- Backpressure: ready=0 for 5 cycles during HOLD → instr_out and instr_valid stable, no mem_rd_en, pc stays 0; ready=1 → pc=1 next cycle.
- Halt: PROG_LEN=4, run=1, ready=1 → addresses 0,1,2,3 issued; after the 4th handshake halted=1, instr_valid=0, no further reads; pc_load=1 with addr=0 → halted=0, IDLE, fetch restarts at 0.
- Load: pc_load=1, addr=8'h20 on a HOLD handshake → next mem_addr=8'h20; pc_load asserted during WAIT → ignored, next address is pc+1.
- Slow memory and run drop: mem_rvalid 4 cycles after the strobe, run dropped during WAIT → word still issued, then IDLE with no new mem_rd_en; a stray mem_rvalid while in IDLE leaves instr_out unchanged.
- Reset mid-WAIT: rst during WAIT → all outputs at reset values next cycle; the late mem_rvalid is ignored.
